// File: rtl/switch_mcu_pkg.sv
// Shared constants for the switch MCU fetch/decode path: RV32I encodings,
// one-hot instruction strobe indices and fetch FSM state encodings.
package switch_mcu_pkg;

    localparam int INST_NUM = 47;

    localparam int INST_LUI    = 0;
    localparam int INST_AUIPC  = 1;
    localparam int INST_JAL    = 2;
    localparam int INST_JALR   = 3;
    localparam int INST_BEQ    = 4;
    localparam int INST_BNE    = 5;
    localparam int INST_BLT    = 6;
    localparam int INST_BGE    = 7;
    localparam int INST_BLTU   = 8;
    localparam int INST_BGEU   = 9;
    localparam int INST_LB     = 10;
    localparam int INST_LH     = 11;
    localparam int INST_LW     = 12;
    localparam int INST_LBU    = 13;
    localparam int INST_LHU    = 14;
    localparam int INST_SB     = 15;
    localparam int INST_SH     = 16;
    localparam int INST_SW     = 17;
    localparam int INST_ADDI   = 18;
    localparam int INST_SLTI   = 19;
    localparam int INST_SLTIU  = 20;
    localparam int INST_XORI   = 21;
    localparam int INST_ORI    = 22;
    localparam int INST_ANDI   = 23;
    localparam int INST_SLLI   = 24;
    localparam int INST_SRLI   = 25;
    localparam int INST_SRAI   = 26;
    localparam int INST_ADD    = 27;
    localparam int INST_SUB    = 28;
    localparam int INST_SLL    = 29;
    localparam int INST_SLT    = 30;
    localparam int INST_SLTU   = 31;
    localparam int INST_XOR    = 32;
    localparam int INST_SRL    = 33;
    localparam int INST_SRA    = 34;
    localparam int INST_OR     = 35;
    localparam int INST_AND    = 36;
    localparam int INST_FENCE  = 37;
    localparam int INST_FENCEI = 38;
    localparam int INST_ECALL  = 39;
    localparam int INST_EBREAK = 40;
    localparam int INST_CSRRW  = 41;
    localparam int INST_CSRRS  = 42;
    localparam int INST_CSRRC  = 43;
    localparam int INST_CSRRWI = 44;
    localparam int INST_CSRRSI = 45;
    localparam int INST_CSRRCI = 46;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_REG      = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_000 = 3'b000;
    localparam logic [2:0] F3_001 = 3'b001;
    localparam logic [2:0] F3_010 = 3'b010;
    localparam logic [2:0] F3_011 = 3'b011;
    localparam logic [2:0] F3_100 = 3'b100;
    localparam logic [2:0] F3_101 = 3'b101;
    localparam logic [2:0] F3_110 = 3'b110;
    localparam logic [2:0] F3_111 = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] ENC_ECALL  = 32'h0000_0073;
    localparam logic [31:0] ENC_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_UPDATE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/switch_mcu_decoder.sv
// Combinational RV32I decoder: exact-match one-hot strobes, illegal flag,
// register indices and raw immediate fields.
module switch_mcu_decoder
    import switch_mcu_pkg::*;
(
    input  logic [31:0]         inst,
    output logic [INST_NUM-1:0] inst_vec,
    output logic                illegal,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [11:0]         imm_i,
    output logic [11:0]         imm_s,
    output logic [11:0]         imm_b,
    output logic [19:0]         imm_u,
    output logic [18:0]         imm_j
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];

    assign rs1   = inst[19:15];
    assign rs2   = inst[24:20];
    assign rd    = inst[11:7];
    assign imm_i = inst[31:20];
    assign imm_s = {inst[31:25], inst[11:7]};
    assign imm_b = {inst[31], inst[7], inst[30:25], inst[11:8]};
    assign imm_u = inst[31:12];
    // imm[1] is not carried, so a jal with inst[21] set cannot be represented
    assign imm_j = {inst[31], inst[19:12], inst[20], inst[30:22]};

    always_comb begin
        inst_vec = '0;
        case (opcode)
            OP_LUI:   inst_vec[INST_LUI]   = 1'b1;
            OP_AUIPC: inst_vec[INST_AUIPC] = 1'b1;
            OP_JAL:   inst_vec[INST_JAL]   = ~inst[21];
            OP_JALR:  inst_vec[INST_JALR]  = (f3 == F3_000);
            OP_BRANCH: begin
                inst_vec[INST_BEQ]  = (f3 == F3_000);
                inst_vec[INST_BNE]  = (f3 == F3_001);
                inst_vec[INST_BLT]  = (f3 == F3_100);
                inst_vec[INST_BGE]  = (f3 == F3_101);
                inst_vec[INST_BLTU] = (f3 == F3_110);
                inst_vec[INST_BGEU] = (f3 == F3_111);
            end
            OP_LOAD: begin
                inst_vec[INST_LB]  = (f3 == F3_000);
                inst_vec[INST_LH]  = (f3 == F3_001);
                inst_vec[INST_LW]  = (f3 == F3_010);
                inst_vec[INST_LBU] = (f3 == F3_100);
                inst_vec[INST_LHU] = (f3 == F3_101);
            end
            OP_STORE: begin
                inst_vec[INST_SB] = (f3 == F3_000);
                inst_vec[INST_SH] = (f3 == F3_001);
                inst_vec[INST_SW] = (f3 == F3_010);
            end
            OP_IMM: begin
                inst_vec[INST_ADDI]  = (f3 == F3_000);
                inst_vec[INST_SLTI]  = (f3 == F3_010);
                inst_vec[INST_SLTIU] = (f3 == F3_011);
                inst_vec[INST_XORI]  = (f3 == F3_100);
                inst_vec[INST_ORI]   = (f3 == F3_110);
                inst_vec[INST_ANDI]  = (f3 == F3_111);
                inst_vec[INST_SLLI]  = (f3 == F3_001) && (f7 == F7_BASE);
                inst_vec[INST_SRLI]  = (f3 == F3_101) && (f7 == F7_BASE);
                inst_vec[INST_SRAI]  = (f3 == F3_101) && (f7 == F7_ALT);
            end
            OP_REG: begin
                inst_vec[INST_ADD]  = (f3 == F3_000) && (f7 == F7_BASE);
                inst_vec[INST_SUB]  = (f3 == F3_000) && (f7 == F7_ALT);
                inst_vec[INST_SLL]  = (f3 == F3_001) && (f7 == F7_BASE);
                inst_vec[INST_SLT]  = (f3 == F3_010) && (f7 == F7_BASE);
                inst_vec[INST_SLTU] = (f3 == F3_011) && (f7 == F7_BASE);
                inst_vec[INST_XOR]  = (f3 == F3_100) && (f7 == F7_BASE);
                inst_vec[INST_SRL]  = (f3 == F3_101) && (f7 == F7_BASE);
                inst_vec[INST_SRA]  = (f3 == F3_101) && (f7 == F7_ALT);
                inst_vec[INST_OR]   = (f3 == F3_110) && (f7 == F7_BASE);
                inst_vec[INST_AND]  = (f3 == F3_111) && (f7 == F7_BASE);
            end
            OP_MISC_MEM: begin
                inst_vec[INST_FENCE]  = (f3 == F3_000);
                inst_vec[INST_FENCEI] = (f3 == F3_001);
            end
            OP_SYSTEM: begin
                inst_vec[INST_ECALL]  = (inst == ENC_ECALL);
                inst_vec[INST_EBREAK] = (inst == ENC_EBREAK);
                inst_vec[INST_CSRRW]  = (f3 == F3_001);
                inst_vec[INST_CSRRS]  = (f3 == F3_010);
                inst_vec[INST_CSRRC]  = (f3 == F3_011);
                inst_vec[INST_CSRRWI] = (f3 == F3_101);
                inst_vec[INST_CSRRSI] = (f3 == F3_110);
                inst_vec[INST_CSRRCI] = (f3 == F3_111);
            end
            default: inst_vec = '0;
        endcase
    end

    assign illegal = (inst_vec == '0);

endmodule

// File: rtl/switch_mcu_fetch_ctrl.sv
// Fetch/execute sequencer for the multi-cycle core: owns the PC, the
// instruction register and the per-instruction step counter.
module switch_mcu_fetch_ctrl
    import switch_mcu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          EXEC_CYCLES = 4
) (
    input  logic                in_clk,
    input  logic                in_rst,
    output logic                out_imem_req,
    output logic [31:0]         out_imem_addr,
    input  logic                in_imem_ack,
    input  logic [31:0]         in_imem_rdata,
    input  logic                in_stall,
    input  logic                in_pc_load,
    input  logic [31:0]         in_pc_target,
    output logic [31:0]         out_pc_reg,
    output logic [3:0]          out_cycle_cnt,
    output logic [INST_NUM-1:0] out_inst,
    output logic                out_illegal,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [4:0]          out_rd,
    output logic [11:0]         out_imm_type_i,
    output logic [11:0]         out_imm_type_s,
    output logic [11:0]         out_imm_type_b,
    output logic [19:0]         out_imm_type_u,
    output logic [18:0]         out_imm_type_j
);

    localparam logic [3:0] CNT_LAST = 4'(EXEC_CYCLES - 1);

    fetch_state_t  state_reg, state_next;
    logic [31:0]   pc_reg;
    logic [31:0]   inst_reg;
    logic [31:0]   target_reg;
    logic          redirect_reg;
    logic [3:0]    cnt_reg;
    logic [INST_NUM-1:0] dec_vec;
    logic          dec_illegal;
    logic          exec_last;

    assign exec_last = (cnt_reg == CNT_LAST) && !in_stall;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH:  if (in_imem_ack) state_next = ST_EXEC;
            ST_EXEC:   if (exec_last)   state_next = ST_UPDATE;
            ST_UPDATE: state_next = ST_FETCH;
            default:   state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_reg    <= ST_FETCH;
            pc_reg       <= RESET_PC;
            inst_reg     <= '0;
            target_reg   <= '0;
            redirect_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_FETCH: begin
                    cnt_reg <= '0;
                    if (in_imem_ack) inst_reg <= in_imem_rdata;
                end
                ST_EXEC: begin
                    // the last pulse wins; the flag stays set until UPDATE
                    if (in_pc_load) begin
                        redirect_reg <= 1'b1;
                        target_reg   <= in_pc_target;
                    end
                    if (exec_last)     cnt_reg <= '0;
                    else if (!in_stall) cnt_reg <= cnt_reg + 4'd1;
                end
                ST_UPDATE: begin
                    pc_reg       <= redirect_reg ? (target_reg & ~32'h1) : (pc_reg + 32'd4);
                    redirect_reg <= 1'b0;
                    cnt_reg      <= '0;
                end
                default: cnt_reg <= '0;
            endcase
        end
    end

    switch_mcu_decoder u_decoder (
        .inst     (inst_reg),
        .inst_vec (dec_vec),
        .illegal  (dec_illegal),
        .rs1      (out_rs1),
        .rs2      (out_rs2),
        .rd       (out_rd),
        .imm_i    (out_imm_type_i),
        .imm_s    (out_imm_type_s),
        .imm_b    (out_imm_type_b),
        .imm_u    (out_imm_type_u),
        .imm_j    (out_imm_type_j)
    );

    assign out_imem_req  = (state_reg == ST_FETCH) && !in_rst;
    assign out_imem_addr = pc_reg;
    assign out_pc_reg    = pc_reg;
    assign out_cycle_cnt = cnt_reg;
    assign out_inst      = (state_reg == ST_EXEC) ? dec_vec : '0;
    assign out_illegal   = (state_reg == ST_EXEC) && dec_illegal;

endmodule
